phys_reg_free_list: RTL and testbench

- Circular free list of physical integer register tags for the renaming core.
- Upstream, rename pops one free tag per cycle for each instruction that writes a GPR.
- Downstream of commit: each committing GPR-writer returns the tag its destination previously mapped.
- Keeps a speculative head and an architectural head, so a pipeline flush reclaims every tag allocated since the last commit in one cycle.

---
 rtl/phys_reg_free_list_pkg.sv | 33 +++
 rtl/free_list_release_compact.sv | 31 +++
 rtl/phys_reg_free_list_chk.sv | 23 ++
 rtl/phys_reg_free_list.sv | 108 ++++++++++
 tb/tb_phys_reg_free_list.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/phys_reg_free_list_pkg.sv
// Physical-register tag types and free-list sizing shared by rename, commit and the free list.
// Also provides the modulo-DEPTH pointer increment used by every free-list pointer.
package phys_reg_free_list_pkg;

  localparam int unsigned NR_COMMIT_PORTS = 2;
  localparam int unsigned NR_PHYS_REGS    = 64;
  localparam int unsigned NR_ARCH_REGS    = 32;
  localparam int unsigned PHYS_REG_BITS   = $clog2(NR_PHYS_REGS);

  localparam int unsigned FL_DEPTH    = NR_PHYS_REGS - NR_ARCH_REGS;
  localparam int unsigned FL_PTR_BITS = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;
  localparam int unsigned FL_CNT_BITS = $clog2(FL_DEPTH + 1);

  typedef logic [PHYS_REG_BITS-1:0] phys_reg_t;
  typedef logic [FL_PTR_BITS-1:0]   fl_ptr_t;
  typedef logic [FL_CNT_BITS-1:0]   fl_cnt_t;

  localparam fl_cnt_t FL_DEPTH_CNT = fl_cnt_t'(FL_DEPTH);
  localparam fl_cnt_t FL_CNT_ZERO  = {FL_CNT_BITS{1'b0}};
  localparam fl_cnt_t FL_CNT_ONE   = {{(FL_CNT_BITS-1){1'b0}}, 1'b1};
  localparam fl_ptr_t FL_PTR_ZERO  = {FL_PTR_BITS{1'b0}};

  // DEPTH need not be a power of two, so wrap by compare-and-subtract.
  function automatic fl_ptr_t fl_ptr_add(input fl_ptr_t ptr, input fl_cnt_t inc);
    logic [FL_CNT_BITS:0] sum;
    sum = {{(FL_CNT_BITS+1-FL_PTR_BITS){1'b0}}, ptr} + {1'b0, inc};
    if (sum >= {1'b0, FL_DEPTH_CNT}) begin
      sum = sum - {1'b0, FL_DEPTH_CNT};
    end
    return sum[FL_PTR_BITS-1:0];
  endfunction

endpackage

// File: rtl/free_list_release_compact.sv
// Packs the valid commit-port release tags into consecutive slots, port 0 first,
// and reports how many were valid.
module free_list_release_compact
  import phys_reg_free_list_pkg::*;
(
  input  logic      [NR_COMMIT_PORTS-1:0] valid_i,
  input  phys_reg_t [NR_COMMIT_PORTS-1:0] tag_i,
  output phys_reg_t [NR_COMMIT_PORTS-1:0] tags_o,
  output fl_cnt_t                         nrel_o
);

  localparam int unsigned IDX_BITS = (NR_COMMIT_PORTS > 1) ? $clog2(NR_COMMIT_PORTS) : 1;

  fl_cnt_t w_cnt;

  // Port-order compaction; the running count is the next free slot index.
  always_comb begin
    tags_o = {(NR_COMMIT_PORTS*PHYS_REG_BITS){1'b0}};
    w_cnt  = FL_CNT_ZERO;
    for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
      if (valid_i[p]) begin
        tags_o[w_cnt[IDX_BITS-1:0]] = tag_i[p];
        w_cnt = w_cnt + FL_CNT_ONE;
      end else begin
        w_cnt = w_cnt;
      end
    end
    nrel_o = w_cnt;
  end

endmodule

// File: rtl/phys_reg_free_list_chk.sv
// Simulation-only checker for free-list misuse: double free and release of tag 0.
module phys_reg_free_list_chk
  import phys_reg_free_list_pkg::*;
(
  input logic                            clk_i,
  input logic                            rst_ni,
  input fl_cnt_t                         spec_cnt_i,
  input fl_cnt_t                         nrel_i,
  input logic      [NR_COMMIT_PORTS-1:0] release_valid_i,
  input phys_reg_t [NR_COMMIT_PORTS-1:0] release_tag_i
);

  // Sample the release side every active cycle.
  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (({1'b0, spec_cnt_i} + {1'b0, nrel_i}) <= {1'b0, FL_DEPTH_CNT});
      for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
        assert (!release_valid_i[p] || (release_tag_i[p] != {PHYS_REG_BITS{1'b0}}));
      end
    end
  end

endmodule

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags with speculative and architectural heads.
// Optional stall counter enabled by defining FREE_LIST_PERF_EN.
module phys_reg_free_list
  import phys_reg_free_list_pkg::*;
(
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            flush_i,
  input  logic                            alloc_req_i,
  output logic                            alloc_ready_o,
  output phys_reg_t                       alloc_tag_o,
  input  logic      [NR_COMMIT_PORTS-1:0] release_valid_i,
  input  phys_reg_t [NR_COMMIT_PORTS-1:0] release_tag_i,
  output logic      [FL_CNT_BITS-1:0]     free_count_o,
  output logic      [31:0]                alloc_stall_cnt_o
);

  phys_reg_t r_mem [FL_DEPTH];
  fl_ptr_t   r_spec_head;
  fl_ptr_t   r_arch_head;
  fl_ptr_t   r_tail;
  fl_cnt_t   r_spec_cnt;

  logic                            w_ready;
  logic                            w_fire;
  fl_cnt_t                         w_nrel;
  phys_reg_t [NR_COMMIT_PORTS-1:0] w_rel_tags;
  fl_ptr_t                         w_arch_head_nxt;

  free_list_release_compact u_compact (
    .valid_i (release_valid_i),
    .tag_i   (release_tag_i),
    .tags_o  (w_rel_tags),
    .nrel_o  (w_nrel)
  );

  assign w_ready         = (r_spec_cnt != FL_CNT_ZERO);
  assign w_fire          = alloc_req_i && w_ready && !flush_i;
  assign w_arch_head_nxt = fl_ptr_add(r_arch_head, w_nrel);

  assign alloc_ready_o = w_ready;
  assign alloc_tag_o   = r_mem[r_spec_head];
  assign free_count_o  = r_spec_cnt;

  // Pointers and speculative count; every commit retires one list entry, so arch_cnt stays DEPTH.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_spec_head <= FL_PTR_ZERO;
      r_arch_head <= FL_PTR_ZERO;
      r_tail      <= FL_PTR_ZERO;
      r_spec_cnt  <= FL_DEPTH_CNT;
    end else begin
      r_tail      <= fl_ptr_add(r_tail, w_nrel);
      r_arch_head <= w_arch_head_nxt;
      if (flush_i) begin
        r_spec_head <= w_arch_head_nxt;
        r_spec_cnt  <= FL_DEPTH_CNT;
      end else begin
        r_spec_head <= w_fire ? fl_ptr_add(r_spec_head, FL_CNT_ONE) : r_spec_head;
        r_spec_cnt  <= r_spec_cnt - (w_fire ? FL_CNT_ONE : FL_CNT_ZERO) + w_nrel;
      end
    end
  end

  // Tag storage: reset to the tags above the architectural range, then filled at the tail.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        r_mem[i] <= phys_reg_t'(NR_ARCH_REGS + i);
      end
    end else begin
      for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
        if (fl_cnt_t'(k) < w_nrel) begin
          r_mem[fl_ptr_add(r_tail, fl_cnt_t'(k))] <= w_rel_tags[k];
        end
      end
    end
  end

`ifdef FREE_LIST_PERF_EN
  logic [31:0] r_stall_cnt;

  // Saturating count of cycles where rename wanted a tag and none was free.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_stall_cnt <= 32'd0;
    end else if (alloc_req_i && !w_ready && !flush_i && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign alloc_stall_cnt_o = r_stall_cnt;
`else
  assign alloc_stall_cnt_o = 32'd0;
`endif

`ifndef SYNTHESIS
  phys_reg_free_list_chk u_chk (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .spec_cnt_i      (r_spec_cnt),
    .nrel_i          (w_nrel),
    .release_valid_i (release_valid_i),
    .release_tag_i   (release_tag_i)
  );
`endif

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed self-checking bench for phys_reg_free_list (default 64 phys / 32 arch / 2 commit ports).
module tb_phys_reg_free_list;
  import phys_reg_free_list_pkg::*;

  logic                            clk_i = 1'b0;
  logic                            rst_ni;
  logic                            flush_i;
  logic                            alloc_req_i;
  logic                            alloc_ready_o;
  phys_reg_t                       alloc_tag_o;
  logic      [NR_COMMIT_PORTS-1:0] release_valid_i;
  phys_reg_t [NR_COMMIT_PORTS-1:0] release_tag_i;
  logic      [FL_CNT_BITS-1:0]     free_count_o;
  logic      [31:0]                alloc_stall_cnt_o;

  int n_checks = 0;
  int n_err    = 0;

  phys_reg_free_list dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .flush_i           (flush_i),
    .alloc_req_i       (alloc_req_i),
    .alloc_ready_o     (alloc_ready_o),
    .alloc_tag_o       (alloc_tag_o),
    .release_valid_i   (release_valid_i),
    .release_tag_i     (release_tag_i),
    .free_count_o      (free_count_o),
    .alloc_stall_cnt_o (alloc_stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int  q[$];
  int  exp_tag;
  int  outstanding;
  int  n_seen;
  bit  seen [NR_PHYS_REGS];

  initial begin
    rst_ni          = 1'b0;
    flush_i         = 1'b0;
    alloc_req_i     = 1'b0;
    release_valid_i = 2'b00;
    release_tag_i   = '0;
    tick();
    tick();
    rst_ni = 1'b1;

    // Reset state
    chk("rst_ready", {31'd0, alloc_ready_o}, 32'd1);
    chk("rst_tag", {26'd0, alloc_tag_o}, 32'd32);
    chk("rst_count", {26'd0, free_count_o}, 32'd32);
    chk("rst_stall", alloc_stall_cnt_o, 32'd0);

    // Drain all 32 tags in order
    alloc_req_i = 1'b1;
    for (int i = 0; i < 32; i++) begin
      chk("drain_tag", {26'd0, alloc_tag_o}, 32'(32 + i));
      tick();
    end
    chk("empty_ready", {31'd0, alloc_ready_o}, 32'd0);
    chk("empty_count", {26'd0, free_count_o}, 32'd0);
    repeat (5) tick();
`ifdef FREE_LIST_PERF_EN
    chk("stall_cnt", alloc_stall_cnt_o, 32'd5);
`else
    chk("stall_cnt_off", alloc_stall_cnt_o, 32'd0);
`endif
    chk("empty_hold_count", {26'd0, free_count_o}, 32'd0);
    alloc_req_i = 1'b0;

    // Dual release into an empty list
    release_valid_i  = 2'b11;
    release_tag_i[0] = 6'd40;
    release_tag_i[1] = 6'd41;
    tick();
    release_valid_i = 2'b00;
    chk("dual_rel_count", {26'd0, free_count_o}, 32'd2);
    chk("dual_rel_tag", {26'd0, alloc_tag_o}, 32'd40);
    alloc_req_i = 1'b1;
    tick();
    alloc_req_i = 1'b0;
    chk("dual_rel_next_tag", {26'd0, alloc_tag_o}, 32'd41);
    chk("dual_rel_next_count", {26'd0, free_count_o}, 32'd1);

    // Port 1 only: its tag lands at the tail, behind 41
    release_valid_i  = 2'b10;
    release_tag_i[0] = 6'd9;
    release_tag_i[1] = 6'd50;
    tick();
    release_valid_i = 2'b00;
    chk("p1_rel_count", {26'd0, free_count_o}, 32'd2);
    chk("p1_rel_head_tag", {26'd0, alloc_tag_o}, 32'd41);
    alloc_req_i = 1'b1;
    tick();
    chk("p1_rel_tag50", {26'd0, alloc_tag_o}, 32'd50);
    chk("p1_rel_count1", {26'd0, free_count_o}, 32'd1);
    tick();
    alloc_req_i = 1'b0;
    chk("p1_rel_count0", {26'd0, free_count_o}, 32'd0);

    // Flush after 10 allocs and 3 commits
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    chk("rst2_count", {26'd0, free_count_o}, 32'd32);
    alloc_req_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("alloc10_tag", {26'd0, alloc_tag_o}, 32'(32 + i));
      tick();
    end
    alloc_req_i = 1'b0;
    chk("alloc10_count", {26'd0, free_count_o}, 32'd22);
    release_valid_i  = 2'b11;
    release_tag_i[0] = 6'd5;
    release_tag_i[1] = 6'd6;
    tick();
    release_valid_i  = 2'b01;
    release_tag_i[0] = 6'd7;
    tick();
    release_valid_i = 2'b00;
    chk("commit3_count", {26'd0, free_count_o}, 32'd25);
    chk("commit3_tag", {26'd0, alloc_tag_o}, 32'd42);
    flush_i     = 1'b1;
    alloc_req_i = 1'b1;
    tick();
    flush_i     = 1'b0;
    alloc_req_i = 1'b0;
    chk("flush_count", {26'd0, free_count_o}, 32'd32);
    chk("flush_tag", {26'd0, alloc_tag_o}, 32'd35);
    chk("flush_ready", {31'd0, alloc_ready_o}, 32'd1);

    // Reset in the middle of an allocation burst
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    alloc_req_i = 1'b1;
    repeat (25) tick();
    chk("burst_count", {26'd0, free_count_o}, 32'd7);
    chk("burst_tag", {26'd0, alloc_tag_o}, 32'd57);
    rst_ni = 1'b0;
    tick();
    rst_ni      = 1'b1;
    alloc_req_i = 1'b0;
    chk("midrst_count", {26'd0, free_count_o}, 32'd32);
    chk("midrst_tag", {26'd0, alloc_tag_o}, 32'd32);
    chk("midrst_stall", alloc_stall_cnt_o, 32'd0);

    // Pointer wrap: one tag in flight, 100 alloc/release pairs
    for (int t = 32; t < 64; t++) q.push_back(t);
    alloc_req_i = 1'b1;
    exp_tag = q.pop_front();
    chk("wrap_first", {26'd0, alloc_tag_o}, 32'(exp_tag));
    seen[alloc_tag_o] = 1'b1;
    outstanding = exp_tag;
    tick();
    for (int n = 0; n < 100; n++) begin
      release_valid_i  = 2'b01;
      release_tag_i[0] = phys_reg_t'(outstanding);
      exp_tag = q.pop_front();
      chk("wrap_tag", {26'd0, alloc_tag_o}, 32'(exp_tag));
      chk("wrap_nodup", {31'd0, (32'(alloc_tag_o) != 32'(outstanding))}, 32'd1);
      seen[alloc_tag_o] = 1'b1;
      q.push_back(outstanding);
      outstanding = exp_tag;
      tick();
    end
    alloc_req_i     = 1'b0;
    release_valid_i = 2'b00;
    chk("wrap_count", {26'd0, free_count_o}, 32'd31);
    n_seen = 0;
    for (int t = 32; t < 64; t++) if (seen[t]) n_seen++;
    chk("wrap_all_reissued", 32'(n_seen), 32'd32);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
